// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle RV32 main control unit: opcodes, FSM states and
// datapath select encodings.
package mc_pkg;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPCODE_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecuteR,
    StExecuteI,
    StAluWb,
    StBeq,
    StJal,
    StLui,
    StFault
  } state_e;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMMEXT    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/mc_imm_decode.sv
// Combinational opcode to immediate-format decode for the multicycle controller.
module mc_imm_decode
  import mc_pkg::*;
(
  input  logic [6:0] op_i,
  output logic [2:0] imm_src_o
);

  always_comb begin
    imm_src_o = IMM_I;
    case (op_i)
      OPCODE_LOAD,
      OPCODE_ITYPE:  imm_src_o = IMM_I;
      OPCODE_STORE:  imm_src_o = IMM_S;
      OPCODE_BRANCH: imm_src_o = IMM_B;
      OPCODE_JAL:    imm_src_o = IMM_J;
      OPCODE_LUI:    imm_src_o = IMM_U;
      default:       imm_src_o = IMM_I;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32 main control FSM with memory-wait watchdog.
// Optional feature macro: RV_JUMP_EN (adds JAL and LUI states and decodes).
module mc_controller
  import mc_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [6:0] op_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       pc_update_o,
  output logic       branch_o,
  output logic       reg_write_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       adr_src_o,
  output logic [1:0] result_src_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [2:0] imm_src_o,
  output logic       fault_o
);

  localparam int unsigned CntW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

  state_e          state_q, state_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            mem_req;
  logic            timeout;

  // Zero is consumed by the external PC-select logic together with Branch.
  logic unused_zero;
  assign unused_zero = zero_i;

  mc_imm_decode u_imm_decode (
    .op_i      (op_i),
    .imm_src_o (imm_src_o)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StFetch;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Memory request decoded from state alone so the watchdog has no path through the FSM logic.
  always_comb begin
    mem_req    = (state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite);
    wait_cnt_d = '0;
    if (mem_req && !mem_ready_i) wait_cnt_d = wait_cnt_q + 1'b1;
    timeout = (WAIT_MAX != 0) && mem_req && !mem_ready_i && (wait_cnt_q == CntW'(WAIT_MAX));
  end

  assign mem_req_o = mem_req;

  always_comb begin
    state_d      = state_q;
    pc_update_o  = 1'b0;
    branch_o     = 1'b0;
    reg_write_o  = 1'b0;
    mem_write_o  = 1'b0;
    ir_write_o   = 1'b0;
    adr_src_o    = 1'b0;
    result_src_o = RES_ALUOUT;
    alu_src_a_o  = SRCA_PC;
    alu_src_b_o  = SRCB_RS2;
    alu_op_o     = ALUOP_ADD;
    fault_o      = 1'b0;

    unique case (state_q)
      StFetch: begin
        alu_src_b_o  = SRCB_FOUR;
        result_src_o = RES_ALURESULT;
        ir_write_o   = mem_ready_i;
        pc_update_o  = mem_ready_i;
        if (mem_ready_i) state_d = StDecode;
      end
      StDecode: begin
        alu_src_a_o = SRCA_OLDPC;
        alu_src_b_o = SRCB_IMM;
        case (op_i)
          OPCODE_LOAD,
          OPCODE_STORE:  state_d = StMemAdr;
          OPCODE_RTYPE:  state_d = StExecuteR;
          OPCODE_ITYPE:  state_d = StExecuteI;
          OPCODE_BRANCH: state_d = StBeq;
`ifdef RV_JUMP_EN
          OPCODE_JAL:    state_d = StJal;
          OPCODE_LUI:    state_d = StLui;
`endif
          default:       state_d = StFault;
        endcase
      end
      StMemAdr: begin
        alu_src_a_o = SRCA_RS1;
        alu_src_b_o = SRCB_IMM;
        state_d     = (op_i == OPCODE_STORE) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        adr_src_o = 1'b1;
        if (mem_ready_i) state_d = StMemWb;
      end
      StMemWb: begin
        result_src_o = RES_DATA;
        reg_write_o  = 1'b1;
        state_d      = StFetch;
      end
      StMemWrite: begin
        adr_src_o   = 1'b1;
        mem_write_o = 1'b1;
        if (mem_ready_i) state_d = StFetch;
      end
      StExecuteR: begin
        alu_src_a_o = SRCA_RS1;
        alu_op_o    = ALUOP_FUNCT;
        state_d     = StAluWb;
      end
      StExecuteI: begin
        alu_src_a_o = SRCA_RS1;
        alu_src_b_o = SRCB_IMM;
        alu_op_o    = ALUOP_FUNCT;
        state_d     = StAluWb;
      end
      StAluWb: begin
        reg_write_o = 1'b1;
        state_d     = StFetch;
      end
      StBeq: begin
        alu_src_a_o = SRCA_RS1;
        alu_op_o    = ALUOP_SUB;
        branch_o    = 1'b1;
        state_d     = StFetch;
      end
`ifdef RV_JUMP_EN
      StJal: begin
        alu_src_a_o = SRCA_OLDPC;
        alu_src_b_o = SRCB_FOUR;
        pc_update_o = 1'b1;
        state_d     = StAluWb;
      end
      StLui: begin
        result_src_o = RES_IMMEXT;
        reg_write_o  = 1'b1;
        state_d      = StFetch;
      end
`endif
      StFault: begin
        fault_o = 1'b1;
      end
      default: state_d = StFault;
    endcase

    // A completing request never times out: timeout already requires MemReady low.
    if (timeout) state_d = StFault;
  end

endmodule
